// File: rtl/svc_rv_mem_arb_if.sv
// Bundle of the fetch port, data port and memory command/response signals
// around svc_rv_mem_arb. The arbiter uses the slave view; core and memory use master.
interface svc_rv_mem_arb_if #(
  parameter int unsigned AW = 32
);
  localparam int unsigned DW = 32;
  localparam int unsigned SW = DW / 8;

  logic          i_req;
  logic [AW-1:0] i_addr;
  logic          i_gnt;
  logic          i_rvalid;
  logic [DW-1:0] i_rdata;

  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic [SW-1:0] d_wstrb;
  logic          d_gnt;
  logic          d_rvalid;
  logic [DW-1:0] d_rdata;

  logic          m_ready;
  logic          m_ren;
  logic          m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic [SW-1:0] m_wstrb;
  logic [DW-1:0] m_rdata;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_wstrb, m_ready, m_rdata,
    output i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
           m_ren, m_we, m_addr, m_wdata, m_wstrb
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_wstrb, m_ready, m_rdata,
    input  i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
           m_ren, m_we, m_addr, m_wdata, m_wstrb
  );
endinterface

// File: rtl/svc_rv_mem_arb.sv
// Shares one 1-cycle-latency memory between svc_rv fetch and data ports.
// Data wins ties; fetch is forced through after MAX_D_STREAK data grants.
module svc_rv_mem_arb #(
  parameter int unsigned AW           = 32,
  parameter int unsigned MAX_D_STREAK = 3
) (
  input logic              clock,
  input logic              reset,
  svc_rv_mem_arb_if.slave  bus
);
  localparam int unsigned STREAK_W = $clog2(MAX_D_STREAK + 1);
  localparam int unsigned DW       = 32;
  localparam int unsigned BW       = DW / 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DATA  = 2'd2
  } owner_e;

  owner_e              state_q, state_d;
  logic [STREAK_W-1:0] streak_q, streak_d;
  logic                resp_v_q, resp_v_d;

  logic          force_i_c;
  logic          d_gnt_c;
  logic          i_gnt_c;
  logic          m_ren_c;
  logic          m_we_c;
  logic [AW-1:0] m_addr_c;
  logic [DW-1:0] m_wdata_c;
  logic [BW-1:0] m_wstrb_c;

  // State register: owner of the in-flight command, streak, response pending
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      streak_q <= '0;
      resp_v_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      streak_q <= streak_d;
      resp_v_q <= resp_v_d;
    end
  end

  // Grant decision, next owner and starvation streak; grants held off during reset
  always_comb begin
    state_d   = IDLE;
    streak_d  = streak_q;
    force_i_c = bus.i_req && (streak_q == STREAK_W'(MAX_D_STREAK));
    d_gnt_c   = !reset && bus.m_ready && bus.d_req && !force_i_c;
    i_gnt_c   = !reset && bus.m_ready && bus.i_req && !d_gnt_c;

    if (d_gnt_c) begin
      state_d = DATA;
    end else if (i_gnt_c) begin
      state_d = FETCH;
    end

    if (d_gnt_c && bus.i_req) begin
      if (streak_q != STREAK_W'(MAX_D_STREAK)) begin
        streak_d = streak_q + STREAK_W'(1);
      end
    end else if (i_gnt_c || !bus.i_req) begin
      streak_d = '0;
    end

    resp_v_d = m_ren_c;
  end

  // Memory command muxed from the granted requester
  always_comb begin
    m_ren_c   = 1'b0;
    m_we_c    = 1'b0;
    m_addr_c  = bus.d_addr;
    m_wdata_c = bus.d_wdata;
    m_wstrb_c = '0;
    if (d_gnt_c) begin
      m_ren_c   = !bus.d_we;
      m_we_c    = bus.d_we;
      m_wstrb_c = bus.d_wstrb;
    end else if (i_gnt_c) begin
      m_ren_c  = 1'b1;
      m_addr_c = bus.i_addr;
    end
  end

  assign bus.i_gnt   = i_gnt_c;
  assign bus.d_gnt   = d_gnt_c;
  assign bus.m_ren   = m_ren_c;
  assign bus.m_we    = m_we_c;
  assign bus.m_addr  = m_addr_c;
  assign bus.m_wdata = m_wdata_c;
  assign bus.m_wstrb = m_wstrb_c;

  // A response still in flight when reset arrives is dropped
  assign bus.i_rvalid = !reset && resp_v_q && (state_q == FETCH);
  assign bus.d_rvalid = !reset && resp_v_q && (state_q == DATA);
  assign bus.i_rdata  = bus.m_rdata;
  assign bus.d_rdata  = bus.m_rdata;
endmodule

// File: tb/tb_svc_rv_mem_arb.sv
// Self-checking bench for svc_rv_mem_arb: a memory model answers reads one
// cycle late and a scoreboard matches every response to the grant that caused it.
module tb_svc_rv_mem_arb;
  typedef struct {
    logic        tgt;
    logic [31:0] data;
    int unsigned due;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  int unsigned cyc   = 0;
  int          tests_run    = 0;
  int          tests_failed = 0;
  exp_t        exp_q[$];
  logic [31:0] mem [256];

  svc_rv_mem_arb_if #(.AW(32)) bus ();

  svc_rv_mem_arb #(.AW(32), .MAX_D_STREAK(3)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] <= {16'hC0DE, 8'h00, 8'(i)};
    mem[16]  <= 32'h0000_0013;
    mem[128] <= 32'h1122_3344;
  end

  // Memory macro model: 1-cycle read latency, byte-strobed writes
  always @(posedge clock) begin
    if (bus.m_we)
      for (int b = 0; b < 4; b++)
        if (bus.m_wstrb[b]) mem[8'(bus.m_addr >> 2)][8*b +: 8] <= bus.m_wdata[8*b +: 8];
    if (bus.m_ren) bus.m_rdata <= mem[8'(bus.m_addr >> 2)];
  end

  // Scoreboard: each expected response must show up in exactly its due cycle
  always @(negedge clock) begin
    while (exp_q.size() != 0 && exp_q[0].due < cyc) begin
      tests_run++; tests_failed++;
      $display("FAIL resp_missing: no response seen, required tgt=%0d data=%h", exp_q[0].tgt, exp_q[0].data);
      void'(exp_q.pop_front());
    end
    if (exp_q.size() != 0 && exp_q[0].due == cyc) begin
      exp_t e;
      logic [31:0] got;
      e = exp_q.pop_front();
      got = e.tgt ? bus.d_rdata : bus.i_rdata;
      tests_run++;
      if ({bus.i_rvalid, bus.d_rvalid} !== {!e.tgt, e.tgt} || got !== e.data) begin
        tests_failed++;
        $display("FAIL resp: got i_rvalid=%b d_rvalid=%b data=%h, required tgt=%0d data=%h",
                 bus.i_rvalid, bus.d_rvalid, got, e.tgt, e.data);
      end
    end else if (bus.i_rvalid || bus.d_rvalid) begin
      tests_run++; tests_failed++;
      $display("FAIL resp_unexpected: i_rvalid=%b d_rvalid=%b, required none", bus.i_rvalid, bus.d_rvalid);
    end
  end

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    bus.i_req   = 1'b0;
    bus.i_addr  = '0;
    bus.d_req   = 1'b0;
    bus.d_we    = 1'b0;
    bus.d_addr  = '0;
    bus.d_wdata = '0;
    bus.d_wstrb = '0;
    bus.m_ready = 1'b1;
  endtask

  task automatic push_exp(input logic tgt, input logic [31:0] data);
    exp_t e;
    e.tgt = tgt; e.data = data; e.due = cyc + 1;
    exp_q.push_back(e);
  endtask

  task automatic test_reset();
    logic [9:0] obs;
    reset = 1'b1;
    bus.i_req = 1'b1; bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_wstrb = 4'hF;
    next_cycle();
    next_cycle();
    obs = {bus.i_gnt, bus.d_gnt, bus.i_rvalid, bus.d_rvalid, bus.m_ren, bus.m_we, bus.m_wstrb};
    tests_run++;
    if (obs !== 10'b0) begin
      tests_failed++; $display("FAIL reset_outputs: got %b required %b", obs, 10'b0);
    end
    tests_run++;
    if (dut.streak_q !== 2'd0) begin
      tests_failed++; $display("FAIL reset_streak: got %0d required 0", dut.streak_q);
    end
    idle_inputs();
    next_cycle();
    reset = 1'b0;
    next_cycle();
  endtask

  task automatic test_fetch_only();
    bus.i_req = 1'b1; bus.i_addr = 32'h40;
    #1;
    tests_run++;
    if ({bus.i_gnt, bus.d_gnt, bus.m_ren, bus.m_we} !== 4'b1010) begin
      tests_failed++;
      $display("FAIL fetch_grant: got i_gnt,d_gnt,m_ren,m_we=%b required 1010",
               {bus.i_gnt, bus.d_gnt, bus.m_ren, bus.m_we});
    end
    tests_run++;
    if (bus.m_addr !== 32'h40) begin
      tests_failed++; $display("FAIL fetch_addr: got %h required 00000040", bus.m_addr);
    end
    push_exp(1'b0, 32'h0000_0013);
    next_cycle();
    bus.i_req = 1'b0;
    next_cycle();
  endtask

  task automatic test_simultaneous();
    bus.i_req = 1'b1; bus.i_addr = 32'h44;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h100;
    #1;
    tests_run++;
    if ({bus.d_gnt, bus.i_gnt} !== 2'b10 || bus.m_addr !== 32'h100) begin
      tests_failed++;
      $display("FAIL simul_data_first: got d_gnt,i_gnt=%b m_addr=%h required 10 00000100",
               {bus.d_gnt, bus.i_gnt}, bus.m_addr);
    end
    push_exp(1'b1, mem[64]);
    next_cycle();
    bus.d_req = 1'b0;
    #1;
    tests_run++;
    if ({bus.i_gnt, bus.d_rvalid} !== 2'b11 || bus.m_addr !== 32'h44) begin
      tests_failed++;
      $display("FAIL simul_fetch_next: got i_gnt,d_rvalid=%b m_addr=%h required 11 00000044",
               {bus.i_gnt, bus.d_rvalid}, bus.m_addr);
    end
    push_exp(1'b0, mem[17]);
    next_cycle();
    bus.i_req = 1'b0;
    next_cycle();
  endtask

  task automatic test_starvation();
    int s = 0;
    for (int k = 0; k < 8; k++) begin
      logic exp_d;
      bus.i_req = 1'b1; bus.i_addr = 32'h48;
      bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h180 + 32'(4 * k);
      #1;
      exp_d = (k % 4) != 3;
      tests_run++;
      if ({bus.d_gnt, bus.i_gnt} !== {exp_d, !exp_d}) begin
        tests_failed++;
        $display("FAIL starve_grant[%0d]: got d_gnt,i_gnt=%b required %b",
                 k, {bus.d_gnt, bus.i_gnt}, {exp_d, !exp_d});
      end
      if (exp_d) push_exp(1'b1, mem[8'((32'h180 + 32'(4 * k)) >> 2)]);
      else       push_exp(1'b0, mem[18]);
      s = exp_d ? ((s == 3) ? 3 : s + 1) : 0;
      next_cycle();
      tests_run++;
      if (dut.streak_q !== 2'(s)) begin
        tests_failed++; $display("FAIL starve_streak[%0d]: got %0d required %0d", k, dut.streak_q, s);
      end
    end
    idle_inputs();
    next_cycle();
    next_cycle();
  endtask

  task automatic test_write();
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h200;
    bus.d_wdata = 32'hDEAD_BEEF; bus.d_wstrb = 4'h3;
    #1;
    tests_run++;
    if ({bus.d_gnt, bus.m_we, bus.m_ren} !== 3'b110 || bus.m_wstrb !== 4'h3) begin
      tests_failed++;
      $display("FAIL write_cmd: got d_gnt,m_we,m_ren=%b m_wstrb=%h required 110 3",
               {bus.d_gnt, bus.m_we, bus.m_ren}, bus.m_wstrb);
    end
    tests_run++;
    if (bus.m_addr !== 32'h200 || bus.m_wdata !== 32'hDEAD_BEEF) begin
      tests_failed++;
      $display("FAIL write_data: got addr=%h wdata=%h required 00000200 deadbeef", bus.m_addr, bus.m_wdata);
    end
    next_cycle();
    bus.d_we = 1'b0; bus.d_wstrb = 4'h0;
    #1;
    tests_run++;
    if ({bus.i_rvalid, bus.d_rvalid, bus.d_gnt, bus.m_ren} !== 4'b0011) begin
      tests_failed++;
      $display("FAIL write_noresp_readback: got i_rv,d_rv,d_gnt,m_ren=%b required 0011",
               {bus.i_rvalid, bus.d_rvalid, bus.d_gnt, bus.m_ren});
    end
    push_exp(1'b1, 32'h1122_BEEF);
    next_cycle();
    idle_inputs();
    next_cycle();
  endtask

  task automatic test_backpressure();
    bus.m_ready = 1'b0;
    bus.i_req = 1'b1; bus.i_addr = 32'h4C;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h104;
    for (int k = 0; k < 2; k++) begin
      #1;
      tests_run++;
      if ({bus.i_gnt, bus.d_gnt, bus.m_ren, bus.m_we} !== 4'b0000) begin
        tests_failed++;
        $display("FAIL bp_stall[%0d]: got i_gnt,d_gnt,m_ren,m_we=%b required 0000",
                 k, {bus.i_gnt, bus.d_gnt, bus.m_ren, bus.m_we});
      end
      next_cycle();
    end
    bus.m_ready = 1'b1;
    #1;
    tests_run++;
    if ({bus.d_gnt, bus.i_gnt} !== 2'b10) begin
      tests_failed++; $display("FAIL bp_release: got d_gnt,i_gnt=%b required 10", {bus.d_gnt, bus.i_gnt});
    end
    push_exp(1'b1, mem[65]);
    next_cycle();
    idle_inputs();
    next_cycle();
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 4; k++) begin
      bus.i_req = 1'b1; bus.i_addr = 32'(4 * k);
      #1;
      tests_run++;
      if (bus.i_gnt !== 1'b1 || bus.m_addr !== 32'(4 * k)) begin
        tests_failed++;
        $display("FAIL b2b_grant[%0d]: got i_gnt=%b m_addr=%h required 1 %h", k, bus.i_gnt, bus.m_addr, 32'(4 * k));
      end
      push_exp(1'b0, mem[k]);
      next_cycle();
    end
    idle_inputs();
    next_cycle();
  endtask

  task automatic test_reset_mid_read();
    bus.i_req = 1'b1; bus.i_addr = 32'h40;
    #1;
    tests_run++;
    if (bus.i_gnt !== 1'b1) begin
      tests_failed++; $display("FAIL rst_fetch_grant: got %b required 1", bus.i_gnt);
    end
    next_cycle();
    reset = 1'b1; bus.i_req = 1'b0;
    #1;
    tests_run++;
    if ({bus.i_rvalid, bus.d_rvalid, bus.m_ren, bus.m_we, bus.m_wstrb} !== 8'b0) begin
      tests_failed++;
      $display("FAIL rst_fetch_drop: got %b required 00000000",
               {bus.i_rvalid, bus.d_rvalid, bus.m_ren, bus.m_we, bus.m_wstrb});
    end
    next_cycle();
    reset = 1'b0;
    next_cycle();
    bus.i_req = 1'b1; bus.i_addr = 32'h40;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h108;
    #1;
    next_cycle();
    tests_run++;
    if (dut.streak_q !== 2'd1) begin
      tests_failed++; $display("FAIL rst_streak_pre: got %0d required 1", dut.streak_q);
    end
    reset = 1'b1;
    #1;
    tests_run++;
    if ({bus.d_rvalid, bus.i_rvalid, bus.d_gnt, bus.i_gnt} !== 4'b0) begin
      tests_failed++;
      $display("FAIL rst_data_drop: got d_rv,i_rv,d_gnt,i_gnt=%b required 0000",
               {bus.d_rvalid, bus.i_rvalid, bus.d_gnt, bus.i_gnt});
    end
    next_cycle();
    tests_run++;
    if (dut.streak_q !== 2'd0) begin
      tests_failed++; $display("FAIL rst_streak_clear: got %0d required 0", dut.streak_q);
    end
    idle_inputs();
    reset = 1'b0;
    next_cycle();
  endtask

  initial begin
    idle_inputs();
    bus.i_req = 1'b1;
    test_reset();
    test_fetch_only();
    test_simultaneous();
    test_starvation();
    test_write();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_read();
    next_cycle();
    next_cycle();
    next_cycle();
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++; $display("FAIL drain: %0d responses outstanding, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule

// File: doc/svc_rv_mem_arb.md
Name: svc_rv_mem_arb

Overview:
- Two-requester arbiter that shares one single-ported, 1-cycle-latency (BRAM-timed) memory between the svc_rv instruction fetch port and the data port, for unified-memory SoC builds.
- Grants data accesses priority, with a bounded-starvation guarantee for fetch.
- Routes read data back to the requester that issued the read.
- Sits between the svc_rv core and the memory macro.

Parameters:
AW, 32, byte-address width for all ports
MAX_D_STREAK, 3, maximum consecutive data grants while a fetch is waiting; the next grant is forced to fetch

Ports:
clock  in  1  clock
reset  in  1  synchronous active-high reset
i_req  in  1  fetch read request, held until granted
i_addr  in  AW  fetch byte address, word aligned
i_gnt  out  1  fetch request accepted this cycle
i_rvalid  out  1  fetch read data valid
i_rdata  out  32  fetch read data
d_req  in  1  data request, held until granted
d_we  in  1  1 = write, 0 = read
d_addr  in  AW  data byte address
d_wdata  in  32  write data
d_wstrb  in  4  byte write strobes
d_gnt  out  1  data request accepted this cycle
d_rvalid  out  1  data read data valid
d_rdata  out  32  data read data
m_ready  in  1  memory can accept a command this cycle
m_ren  out  1  memory read strobe
m_we  out  1  memory write strobe
m_addr  out  AW  memory address
m_wdata  out  32  memory write data
m_wstrb  out  4  memory write strobes
m_rdata  in  32  memory read data, valid the cycle after an accepted m_ren

Behaviour:
- Interface: reset reset, synchronous, active-high; clock clock.
- Grant logic (combinational):
  - force_i = i_req && streak == MAX_D_STREAK.
  - d_gnt = m_ready && d_req && !force_i.
  - i_gnt = m_ready && i_req && !d_gnt.
  - At most one grant per cycle. Both grants are 0 when m_ready = 0.
- Memory command (combinational, driven from the granted requester):
  - Data grant: m_ren = !d_we, m_we = d_we, m_addr = d_addr, m_wdata = d_wdata, m_wstrb = d_wstrb.
  - Fetch grant: m_ren = 1, m_we = 0, m_addr = i_addr, m_wstrb = 0.
  - No grant: m_ren = m_we = 0 and m_wstrb = 0. m_addr and m_wdata are don't-care.
- Streak counter (width clog2(MAX_D_STREAK+1)):
  - Reset to 0.
  - On d_gnt with i_req = 1: increment, saturating at MAX_D_STREAK.
  - On i_gnt, or whenever i_req = 0: clear to 0.
  - In all other cases: hold.
- Response routing:
  - Registered state resp_v, resp_tgt (0 = fetch, 1 = data), reset 0.
  - Each cycle: resp_v <= m_ren; resp_tgt <= d_gnt.
  - i_rvalid = resp_v && !resp_tgt. d_rvalid = resp_v && resp_tgt.
  - i_rdata = d_rdata = m_rdata, meaningful only when the matching rvalid is 1.
  - Writes never produce rvalid.
  - Read latency is exactly 1 cycle from grant to rvalid.
  - Back-to-back grants are allowed, giving one response per cycle.
- Owner FSM (used for response routing and debug), states IDLE, FETCH, DATA:
  - Next state is DATA on d_gnt, FETCH on i_gnt, otherwise IDLE.
  - Reset state is IDLE.
- m_ready = 0 while a response is outstanding: the response still arrives next cycle. m_ready gates only new acceptances.
- Requests dropped before grant: no memory action. Requesters are required to hold, but the arbiter does not depend on it.
- Reset outputs: i_gnt, d_gnt, i_rvalid, d_rvalid, m_ren, m_we = 0; m_wstrb = 0.
- Reset mid-operation: the outstanding response is discarded (no rvalid next cycle), and the streak clears.

Test Plan:
- Fetch only: i_req=1, i_addr=0x40, m_ready=1, m_rdata=0x00000013 next cycle -> i_gnt=1, m_ren=1, m_addr=0x40; next cycle i_rvalid=1, i_rdata=0x13, d_rvalid=0.
- Simultaneous: i_req=d_req=1, d_we=0, d_addr=0x100 -> d_gnt=1, i_gnt=0, m_addr=0x100; next cycle d_rvalid=1. With d_req dropped, i_gnt=1 the same cycle d_rvalid asserts.
- Starvation bound: i_req held, d_req held for 8 cycles, MAX_D_STREAK=3 -> grant sequence D,D,D,I,D,D,D,I; streak returns to 0 after each I.
- Write: d_req=1, d_we=1, d_addr=0x200, d_wdata=0xDEADBEEF, d_wstrb=0x3 -> m_we=1, m_wstrb=0x3, m_ren=0; no rvalid on either port next cycle.
- Backpressure: m_ready=0 for 2 cycles with both requests held -> no grants, m_ren=m_we=0; on the cycle m_ready=1, d_gnt=1.
- Reset mid-read: i_gnt issued, reset=1 next cycle -> i_rvalid=0, all strobes 0, streak 0.
